// File: rtl/qf_div_if.sv
// Handshake and operand/result bundle for the qf_div quaternion left-divider.
interface qf_div_if #(
    parameter int AW = 16,
    parameter int QW = 32
);
    logic                 start;
    logic signed [AW-1:0] a0, a1, a2, a3;
    logic signed [QW-1:0] q0, q1, q2, q3;
    logic signed [AW-1:0] b0, b1, b2, b3;
    logic                 busy, done, exact, ovf, dz;

    modport master (
        output start, a0, a1, a2, a3, q0, q1, q2, q3,
        input  b0, b1, b2, b3, busy, done, exact, ovf, dz
    );

    modport slave (
        input  start, a0, a1, a2, a3, q0, q1, q2, q3,
        output b0, b1, b2, b3, busy, done, exact, ovf, dz
    );
endinterface

// File: rtl/qf_div.sv
// Iterative quaternion left-divider: B = conj(A)*Q / |A|^2, one shared multiplier, one restoring divider.
// Define QF_DIV_ROUND_EN for round-to-nearest (ties away from zero) instead of truncation.
module qf_div #(
    parameter int AW = 16,
    parameter int QW = 32
) (
    input  logic     clk,
    input  logic     rst,
    qf_div_if.slave  bus
);
    localparam int PW = AW + QW + 2;
    localparam int NW = 2 * AW + 2;
    localparam int RW = NW + 1;
    localparam int MW = AW + QW;
    localparam int BW = $clog2(PW);

    localparam logic [PW:0] POS_LIM = {{(PW + 2 - AW){1'b0}}, {(AW - 1){1'b1}}};
    localparam logic [PW:0] NEG_LIM = POS_LIM + 1'b1;

    typedef enum logic [2:0] {IDLE, NORM, MAC, DIV, DONE} state_t;

    state_t state_q, state_d;

    logic signed [AW-1:0] a_r   [4];
    logic signed [QW-1:0] q_r   [4];
    logic signed [PW-1:0] num_q [4];
    logic signed [AW-1:0] res_q [4];
    logic signed [AW-1:0] b_q   [4];
    logic [NW-1:0]        norm_q;
    logic [3:0]           cnt_q;
    logic [1:0]           comp_q;
    logic [BW-1:0]        bit_q;
    logic [RW-1:0]        rem_q;
    logic [PW-1:0]        dq_q;
    logic                 exact_w, ovf_w, dz_w;
    logic                 busy_q, done_q, exact_q, ovf_q, dz_q;

    logic accept;
    assign accept = (state_q == IDLE) && bus.start && !done_q;

    // Shared multiplier: squares a_j during NORM, a_j * q_(k^j) during MAC.
    logic signed [AW-1:0] mul_a;
    logic signed [QW-1:0] mul_b;
    logic signed [MW-1:0] prod;
    logic                 prod_neg;

    always_comb begin
        mul_a = a_r[cnt_q[1:0]];
        mul_b = {{(QW - AW){a_r[cnt_q[1:0]][AW-1]}}, a_r[cnt_q[1:0]]};
        if (state_q == MAC)
            mul_b = q_r[cnt_q[3:2] ^ cnt_q[1:0]];
        prod = MW'(mul_a) * MW'(mul_b);
        case (cnt_q)
            4'h5, 4'h6, 4'hA, 4'hB, 4'hD, 4'hF: prod_neg = 1'b1;
            default:                            prod_neg = 1'b0;
        endcase
    end

    logic [NW-1:0]        norm_next;
    logic signed [PW-1:0] term, num_base, num_next;

    always_comb begin
        norm_next = norm_q + prod[NW-1:0];
        term      = {{(PW - MW){prod[MW-1]}}, prod};
        num_base  = (cnt_q[1:0] == 2'd0) ? '0 : num_q[cnt_q[3:2]];
        num_next  = prod_neg ? num_base - term : num_base + term;
    end

    // Restoring division step on |n_k|; a fresh component starts with rem=0.
    logic signed [PW-1:0] num_sel;
    logic [PW-1:0]        mag, dq_in, dq_next;
    logic [RW-1:0]        rem_in, trial, rem_next;
    logic                 qbit;

    always_comb begin
        num_sel  = num_q[comp_q];
        mag      = num_sel[PW-1] ? $unsigned(-num_sel) : $unsigned(num_sel);
        rem_in   = (bit_q == '0) ? '0 : rem_q;
        dq_in    = (bit_q == '0) ? mag : dq_q;
        trial    = {rem_in[RW-2:0], dq_in[PW-1]};
        qbit     = trial >= {1'b0, norm_q};
        rem_next = qbit ? trial - {1'b0, norm_q} : trial;
        dq_next  = {dq_in[PW-2:0], qbit};
    end

    logic                 round_up;
    logic [PW:0]          qmag;
    logic signed [AW-1:0] sat_res;
    logic                 sat_ovf;

    always_comb begin
`ifdef QF_DIV_ROUND_EN
        round_up = {rem_next, 1'b0} >= {2'b00, norm_q};
`else
        round_up = 1'b0;
`endif
        qmag    = {1'b0, dq_next} + {{PW{1'b0}}, round_up};
        sat_ovf = 1'b0;
        if (num_sel[PW-1]) begin
            if (qmag > NEG_LIM) begin
                sat_res = {1'b1, {(AW - 1){1'b0}}};
                sat_ovf = 1'b1;
            end else begin
                sat_res = $signed(-qmag[AW-1:0]);
            end
        end else if (qmag > POS_LIM) begin
            sat_res = {1'b0, {(AW - 1){1'b1}}};
            sat_ovf = 1'b1;
        end else begin
            sat_res = $signed(qmag[AW-1:0]);
        end
    end

    logic div_last;
    assign div_last = (bit_q == BW'(PW - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = NORM;
            NORM: if (cnt_q == 4'd3) state_d = (norm_next == '0) ? DONE : MAC;
            MAC:  if (cnt_q == 4'd15) state_d = DIV;
            DIV:  if (div_last && comp_q == 2'd3) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                a_r[i]   <= '0;
                q_r[i]   <= '0;
                num_q[i] <= '0;
                res_q[i] <= '0;
                b_q[i]   <= '0;
            end
            norm_q  <= '0;
            cnt_q   <= '0;
            comp_q  <= '0;
            bit_q   <= '0;
            rem_q   <= '0;
            dq_q    <= '0;
            exact_w <= 1'b0;
            ovf_w   <= 1'b0;
            dz_w    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            exact_q <= 1'b0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (accept) begin
                    a_r[0] <= bus.a0; a_r[1] <= bus.a1; a_r[2] <= bus.a2; a_r[3] <= bus.a3;
                    q_r[0] <= bus.q0; q_r[1] <= bus.q1; q_r[2] <= bus.q2; q_r[3] <= bus.q3;
                    norm_q  <= '0;
                    cnt_q   <= '0;
                    comp_q  <= '0;
                    bit_q   <= '0;
                    exact_w <= 1'b0;
                    ovf_w   <= 1'b0;
                    dz_w    <= 1'b0;
                    busy_q  <= 1'b1;
                end
                NORM: begin
                    norm_q <= norm_next;
                    if (cnt_q == 4'd3) begin
                        cnt_q <= '0;
                        dz_w  <= (norm_next == '0);
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                MAC: begin
                    num_q[cnt_q[3:2]] <= num_next;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        exact_w <= 1'b1;
                        comp_q  <= '0;
                        bit_q   <= '0;
                    end
                end
                DIV: begin
                    rem_q <= rem_next;
                    dq_q  <= dq_next;
                    if (div_last) begin
                        bit_q         <= '0;
                        comp_q        <= comp_q + 2'd1;
                        res_q[comp_q] <= sat_res;
                        if (sat_ovf)         ovf_w   <= 1'b1;
                        if (rem_next != '0)  exact_w <= 1'b0;
                    end else begin
                        bit_q <= bit_q + 1'b1;
                    end
                end
                DONE: begin
                    // Results publish here, so they stay frozen while the next operation runs.
                    for (int i = 0; i < 4; i++)
                        b_q[i] <= dz_w ? '0 : res_q[i];
                    exact_q <= exact_w;
                    ovf_q   <= ovf_w;
                    dz_q    <= dz_w;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.b0    = b_q[0];
    assign bus.b1    = b_q[1];
    assign bus.b2    = b_q[2];
    assign bus.b3    = b_q[3];
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.exact = exact_q;
    assign bus.ovf   = ovf_q;
    assign bus.dz    = dz_q;
endmodule

// File: tb/tb_qf_div.sv
// Directed, table-driven bench for qf_div with hand-computed quotients and latency.
module tb_qf_div;
    localparam int AW = 16;
    localparam int QW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    qf_div_if #(.AW(AW), .QW(QW)) bus ();
    qf_div #(.AW(AW), .QW(QW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int a0, a1, a2, a3;
        int q0, q1, q2, q3;
        int b0, b1, b2, b3;
        int ex, ov, dz;
        int lat;
    } vec_t;

    vec_t vt [6];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.a0 = AW'(v.a0); bus.a1 = AW'(v.a1); bus.a2 = AW'(v.a2); bus.a3 = AW'(v.a3);
        bus.q0 = QW'(v.q0); bus.q1 = QW'(v.q1); bus.q2 = QW'(v.q2); bus.q3 = QW'(v.q3);
    endtask

    // Runs one operation from the current (posedge+1) point; inj>=0 pokes a
    // second start at that edge count, poke_done asserts start during done.
    task automatic run_op(input string nm, input vec_t v, input vec_t alt,
                          input int inj, input bit poke_done);
        int n;
        drive(v);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({nm, " busy_after_start"}, longint'(bus.busy), 1);
        n = 0;
        while (n < 400) begin
            @(posedge clk);
            n++;
            #1;
            if (n == inj) begin
                drive(alt);
                bus.start = 1'b1;
            end
            if (n == inj + 1) bus.start = 1'b0;
            if (bus.done) break;
        end
        chk({nm, " latency"}, longint'(n), longint'(v.lat));
        chk({nm, " b0"}, longint'($signed(bus.b0)), longint'(v.b0));
        chk({nm, " b1"}, longint'($signed(bus.b1)), longint'(v.b1));
        chk({nm, " b2"}, longint'($signed(bus.b2)), longint'(v.b2));
        chk({nm, " b3"}, longint'($signed(bus.b3)), longint'(v.b3));
        chk({nm, " exact"}, longint'(bus.exact), longint'(v.ex));
        chk({nm, " ovf"}, longint'(bus.ovf), longint'(v.ov));
        chk({nm, " dz"}, longint'(bus.dz), longint'(v.dz));
        chk({nm, " busy_at_done"}, longint'(bus.busy), 0);
        if (poke_done) begin
            drive(alt);
            bus.start = 1'b1;
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({nm, " done_pulse_end"}, longint'(bus.done), 0);
        chk({nm, " idle_after_done"}, longint'(bus.busy), 0);
    endtask

    initial begin
        vt[0] = '{1, 2, 3, 4,  -60, 12, 30, 24,   5, 6, 7, 8,        1, 0, 0, 221};
        vt[1] = '{1, 0, 0, 0,  9, -2, 1, 3,       9, -2, 1, 3,       1, 0, 0, 221};
        vt[2] = '{-3, 2, -1, 4, 3, 2, -1, 16,     2, 0, 1, -2,       1, 0, 0, 221};
        vt[3] = '{0, 0, 0, 0,  123, -5, 7, 9,     0, 0, 0, 0,        0, 0, 1, 5};
`ifdef QF_DIV_ROUND_EN
        vt[4] = '{2, 0, 0, 0,  7, -7, 0, 0,       4, -4, 0, 0,       0, 0, 0, 221};
`else
        vt[4] = '{2, 0, 0, 0,  7, -7, 0, 0,       3, -3, 0, 0,       0, 0, 0, 221};
`endif
        vt[5] = '{1, 0, 0, 0,  40000, -40000, 0, 0, 32767, -32768, 0, 0, 1, 1, 0, 221};

        bus.start = 1'b0;
        drive(vt[3]);
        #12;
        chk("reset busy", longint'(bus.busy), 0);
        chk("reset done", longint'(bus.done), 0);
        chk("reset b0", longint'($signed(bus.b0)), 0);
        chk("reset flags", longint'({bus.exact, bus.ovf, bus.dz}), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++)
            run_op($sformatf("vec%0d", i), vt[i], vt[3], -1, 1'b0);

        // Second start mid-operation must not disturb the first.
        run_op("busy_ignore", vt[0], vt[5], 50, 1'b0);

        // Start in the done cycle is dropped; vt[3] would have made busy rise.
        run_op("done_start", vt[1], vt[3], -1, 1'b1);

        // Asynchronous reset partway through DIV.
        drive(vt[2]);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int n = 0; n < 120; n++) @(posedge clk);
        #1;
        chk("hold b0 while busy", longint'($signed(bus.b0)), 9);
        chk("busy mid-div", longint'(bus.busy), 1);
        rst = 1'b0;
        #1;
        chk("mid rst busy", longint'(bus.busy), 0);
        chk("mid rst b", longint'({bus.b0, bus.b1, bus.b2, bus.b3} != '0), 0);
        chk("mid rst flags", longint'({bus.done, bus.exact, bus.ovf, bus.dz}), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        run_op("after_rst", vt[2], vt[3], -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/qf_div.md
Name: qf_div

Overview:
- Iterative quaternion left-divider: the inverse operation of the `qf` quaternion multiplier.
- Given a product Q = A*B (32-bit components) and the left operand A (16-bit components), recovers B = conj(A)*Q / |A|^2.
- Used to check and undo `qf` results, e.g. rotation inversion.
- Uses one shared multiplier and one restoring divider; start/busy/done handshake.

Parameters:
- AW, 16, signed width of A and B components.
- QW, 32, signed width of Q components.
- Derived, not overridable: PW = AW+QW+2, the width of the intermediate numerator.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; sampled only when busy=0.
- a0, a1, a2, a3  input  AW each  signed divisor quaternion A.
- q0, q1, q2, q3  input  QW each  signed product quaternion Q.
- b0, b1, b2, b3  output  AW each  signed result B, registered.
- busy  output  1  high from the edge after start is accepted until done.
- done  output  1  single-cycle pulse when results are valid.
- exact  output  1  all four divisions had zero remainder.
- ovf  output  1  at least one component saturated.
- dz  output  1  |A|^2 == 0.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-low.
- Reset (rst=0, any time, including mid-operation):
  - State to IDLE; all outputs 0 (b0..b3, busy, done, exact, ovf, dz).
  - Any operation in progress is discarded.
- IDLE:
  - start=1 latches a0..a3 and q0..q3, clears exact/ovf/dz, sets busy, goes to NORM.
  - start while busy=1 is ignored; latched operands do not change.
- NORM, 4 cycles: N = sum of ai*ai, unsigned, 2*AW+2 bits, one product per cycle.
  - If N == 0 at the end: dz=1, b=0, exact=0, ovf=0, go to DONE. done asserts 5 edges after the start-sampling edge.
- MAC, 16 cycles: conj(A)*Q, one signed AWxQW product per cycle, accumulated at PW bits with no overflow possible:
  - n0 = a0q0 + a1q1 + a2q2 + a3q3
  - n1 = a0q1 - a1q0 - a2q3 + a3q2
  - n2 = a0q2 + a1q3 - a2q0 - a3q1
  - n3 = a0q3 - a1q2 + a2q1 - a3q0
- DIV, 4 x PW cycles: components in order 0,1,2,3.
  - Sign-magnitude restoring division of |ni| by N, one quotient bit per cycle.
  - The quotient is truncated toward zero; its sign is the sign of ni.
  - Any nonzero remainder clears exact (exact is set at the start of DIV).
  - If the quotient is outside [-2^(AW-1), 2^(AW-1)-1], bi saturates to that bound and ovf=1.
- DONE, 1 cycle: done=1, busy=0, return to IDLE.
  - done rises exactly 21 + 4*PW edges after the start-sampling edge (221 with defaults).
- Outputs b, exact, ovf and dz are updated only at DONE and hold until the next DONE or reset. They stay stable while a new operation is busy.
- start in the same cycle as DONE is ignored. The earliest accepted start is the cycle after done.
- Combinational outputs: none; all outputs are registered.

Optional Feature:
- Macro QF_DIV_ROUND_EN.
- Defined: quotient rounds to nearest, ties away from zero. Round up when 2*remainder >= N, applied before saturation. exact still reflects the raw remainder.
- Undefined: truncation toward zero, as above.
- Latency is identical in both builds.

Test Plan:
- A=(1,2,3,4), Q=(-60,12,30,24), pulse start -> done at edge 221; B=(5,6,7,8); exact=1, ovf=0, dz=0.
- A=(1,0,0,0), Q=(9,-2,1,3) -> B=(9,-2,1,3), exact=1. Then A=(-3,2,-1,4), Q=(3,2,-1,16) -> B=(2,0,1,-2), exact=1.
- A=(0,0,0,0), any Q -> done 5 edges after start; dz=1, B=0, exact=0.
- A=(2,0,0,0), Q=(7,-7,0,0): N=4, n=(14,-14,0,0) -> B=(3,-3,0,0), exact=0. With QF_DIV_ROUND_EN: B=(4,-4,0,0).
- A=(1,0,0,0), Q=(40000,-40000,0,0) -> B=(32767,-32768,0,0), ovf=1, exact=1.
- Second start during busy -> ignored, first result unchanged. rst=0 at cycle 100 of DIV -> busy=0 and all outputs 0 immediately. A fresh start then completes normally.
